// File: rtl/alpha_trim_pkg.sv
// Shared definitions for the alpha-trimmed-mean sequencer: default geometry,
// derived widths and the one-hot state encoding.
package alpha_trim_pkg;

  localparam int DN_DEF       = 25;
  localparam int DW_DEF       = 8;
  localparam int TRIM_DEF     = 4;
  localparam int SW_DEF       = $clog2(DN_DEF);
  localparam int SORT_TIMEOUT = 15;

  // Number of ranks that survive trimming, and the accumulator width that can
  // hold KEEP full-scale elements without overflow.
  function automatic int keep_count(input int dn, input int trim);
    return dn - 2 * trim;
  endfunction

  function automatic int sum_width(input int dw, input int keep);
    return dw + $clog2(keep + 1);
  endfunction

  localparam int KEEP = keep_count(DN_DEF, TRIM_DEF);
  localparam int KW   = $clog2(KEEP + 1);
  localparam int SUMW = sum_width(DW_DEF, KEEP);

  localparam logic [6:0] ST_IDLE    = 7'b0000001;
  localparam logic [6:0] ST_LAUNCH  = 7'b0000010;
  localparam logic [6:0] ST_WAIT    = 7'b0000100;
  localparam logic [6:0] ST_CAPTURE = 7'b0001000;
  localparam logic [6:0] ST_ACCUM   = 7'b0010000;
  localparam logic [6:0] ST_DIV     = 7'b0100000;
  localparam logic [6:0] ST_OUT     = 7'b1000000;

  typedef enum logic [6:0] {
    S_IDLE    = ST_IDLE,
    S_LAUNCH  = ST_LAUNCH,
    S_WAIT    = ST_WAIT,
    S_CAPTURE = ST_CAPTURE,
    S_ACCUM   = ST_ACCUM,
    S_DIV     = ST_DIV,
    S_OUT     = ST_OUT
  } state_t;

endpackage

// File: rtl/alpha_trim_ctrl_if.sv
// Bus bundle between the window generator, the rank sorter, the downstream
// consumer and the alpha-trim sequencer. The slave view is the sequencer.
interface alpha_trim_ctrl_if
  import alpha_trim_pkg::*;
#(
  parameter int DN = DN_DEF,
  parameter int DW = DW_DEF,
  parameter int SW = $clog2(DN)
) ();

  logic              win_valid;
  logic              win_ready;
  logic [DW*DN-1:0]  win_data;
  logic              sort_sig;
  logic [DW*DN-1:0]  sort_data;
  logic              sort_finish;
  logic [SW*DN-1:0]  sequence_sorted;
  logic              mean_valid;
  logic              mean_ready;
  logic [DW-1:0]     mean_data;
  logic              err_timeout;

  modport slave (
    input  win_valid, win_data, sort_finish, sequence_sorted, mean_ready,
    output win_ready, sort_sig, sort_data, mean_valid, mean_data, err_timeout
  );

  modport master (
    output win_valid, win_data, sort_finish, sequence_sorted, mean_ready,
    input  win_ready, sort_sig, sort_data, mean_valid, mean_data, err_timeout
  );

endinterface

// File: rtl/const_div_seq.sv
// Start/done restoring divider by a constant. One quotient bit per cycle,
// DIVIDEND_W cycles after start; done is high during the final iteration so
// the quotient is ready on the following cycle and held until the next start.
module const_div_seq #(
  parameter int DIVIDEND_W = 13,
  parameter int DIVISOR    = 17,
  parameter int QW         = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  output logic                  done,
  output logic [QW-1:0]         quotient
);

  localparam int RW = $clog2(DIVISOR + 1);
  localparam int CW = $clog2(DIVIDEND_W + 1);
  localparam logic [RW-1:0] DIV_LO = RW'(DIVISOR);

  logic [DIVIDEND_W-1:0] dvd;
  logic [RW-1:0]         rem;
  logic [CW-1:0]         cnt;
  logic                  busy;
  logic [RW:0]           trial;
  logic                  fits;

  assign trial    = {rem, dvd[DIVIDEND_W-1]};
  assign fits     = (trial >= {1'b0, DIV_LO});
  assign done     = busy && (cnt == CW'(1));
  assign quotient = dvd[QW-1:0];

  // Shift one dividend bit into the remainder per cycle, subtracting the divisor when it fits.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      dvd  <= '0;
      rem  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= CW'(DIVIDEND_W);
      dvd  <= dividend;
      rem  <= '0;
    end else if (busy) begin
      rem  <= fits ? (trial[RW-1:0] - DIV_LO) : trial[RW-1:0];
      dvd  <= {dvd[DIVIDEND_W-2:0], fits};
      cnt  <= cnt - 1'b1;
      if (cnt == CW'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alpha_trim_ctrl.sv
// Alpha-trim sequencer: takes a window, launches the rank sorter, sums the
// kept middle ranks one per cycle and divides by the kept count with
// round-half-up. Optional sorter watchdog: define ALPHA_TRIM_TIMEOUT_EN to
// fall back to the centre element (flagged by err_timeout) when the sorter
// does not finish in time.
module alpha_trim_ctrl
  import alpha_trim_pkg::*;
#(
  parameter int DN   = DN_DEF,
  parameter int DW   = DW_DEF,
  parameter int SW   = $clog2(DN),
  parameter int TRIM = TRIM_DEF
) (
  input logic               clk,
  input logic               rst,
  alpha_trim_ctrl_if.slave  bus
);

  localparam int KEEP_N = keep_count(DN, TRIM);
  localparam int SUMW_N = sum_width(DW, KEEP_N);
  localparam logic [SW-1:0] K_FIRST = SW'(TRIM);
  localparam logic [SW-1:0] K_LAST  = SW'(DN - 1 - TRIM);

  state_t            state, next_state;
  logic [DW*DN-1:0]  sort_data_q;
  logic [SW*DN-1:0]  seq_q;
  logic [SW-1:0]     k;
  logic [SUMW_N-1:0] sum, sum_next, dividend;
  logic [SW-1:0]     cur_idx;
  logic [DW-1:0]     elem, div_q;
  logic              ready_en, win_ready_c, div_start, div_done, last_rank;

  assign cur_idx   = seq_q[k*SW +: SW];
  assign elem      = sort_data_q[cur_idx*DW +: DW];
  assign sum_next  = sum + SUMW_N'(elem);
  assign dividend  = sum_next + SUMW_N'(KEEP_N / 2);
  assign last_rank = (k == K_LAST);

`ifdef ALPHA_TRIM_TIMEOUT_EN
  localparam int TW = $clog2(SORT_TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
  logic          timeout_hit, timeout_q;
  logic [DW-1:0] centre;

  assign timeout_hit = (wait_cnt == TW'(SORT_TIMEOUT - 1));
  assign centre      = sort_data_q[(DN/2)*DW +: DW];

  // Count WAIT cycles from zero on each entry and remember a watchdog abort until the result is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state != S_WAIT) wait_cnt <= '0;
      else                 wait_cnt <= wait_cnt + 1'b1;
      if (state == S_WAIT && !bus.sort_finish && timeout_hit) timeout_q <= 1'b1;
      else if (state == S_OUT && bus.mean_ready)              timeout_q <= 1'b0;
    end
  end

  assign bus.mean_data   = (state == S_OUT) ? (timeout_q ? centre : div_q) : '0;
  assign bus.err_timeout = timeout_q;
`else
  assign bus.mean_data   = (state == S_OUT) ? div_q : '0;
  assign bus.err_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state decode and the per-state strobes.
  always_comb begin
    next_state     = state;
    win_ready_c    = 1'b0;
    bus.sort_sig   = 1'b0;
    bus.mean_valid = 1'b0;
    div_start      = 1'b0;
    unique case (state)
      S_IDLE: begin
        win_ready_c = ready_en;
        if (bus.win_valid && ready_en) next_state = S_LAUNCH;
      end
      S_LAUNCH: begin
        bus.sort_sig = 1'b1;
        next_state   = S_WAIT;
      end
      S_WAIT: begin
        if (bus.sort_finish) next_state = S_CAPTURE;
`ifdef ALPHA_TRIM_TIMEOUT_EN
        else if (timeout_hit) next_state = S_OUT;
`endif
      end
      S_CAPTURE: next_state = S_ACCUM;
      S_ACCUM: begin
        if (last_rank) begin
          div_start  = 1'b1;
          next_state = S_DIV;
        end
      end
      S_DIV: begin
        if (div_done) next_state = S_OUT;
      end
      S_OUT: begin
        bus.mean_valid = 1'b1;
        if (bus.mean_ready) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign bus.win_ready = win_ready_c;
  assign bus.sort_data = sort_data_q;

  // Window latch, rank snapshot, rank counter and accumulator; ready_en keeps win_ready low in the reset cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sort_data_q <= '0;
      seq_q       <= '0;
      k           <= '0;
      sum         <= '0;
      ready_en    <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        S_IDLE: if (bus.win_valid && win_ready_c) sort_data_q <= bus.win_data;
        S_CAPTURE: begin
          seq_q <= bus.sequence_sorted;
          k     <= K_FIRST;
          sum   <= '0;
        end
        S_ACCUM: begin
          sum <= sum_next;
          k   <= k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  const_div_seq #(
    .DIVIDEND_W(SUMW_N),
    .DIVISOR   (KEEP_N),
    .QW        (DW)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start   (div_start),
    .dividend(dividend),
    .done    (div_done),
    .quotient(div_q)
  );

endmodule

// File: tb/tb_alpha_trim_ctrl.sv
// Directed testbench for alpha_trim_ctrl with a behavioural rank-sorter model.
module tb_alpha_trim_ctrl;

  localparam int DN = 25;
  localparam int DW = 8;
  localparam int SW = 5;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  logic sorter_on = 1'b1;
  int   spur_req = 0;
  int   spur_ack = 0;
  logic [DW*DN-1:0] cur_win = '0;

  alpha_trim_ctrl_if #(.DN(DN), .DW(DW), .SW(SW)) bus ();

  alpha_trim_ctrl dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Stable ascending sort: field k holds the original index of rank k.
  function automatic logic [SW*DN-1:0] compute_seq(input logic [DW*DN-1:0] w);
    logic [SW*DN-1:0] s;
    int r;
    s = '0;
    for (int i = 0; i < DN; i++) begin
      r = 0;
      for (int j = 0; j < DN; j++)
        if (w[j*DW +: DW] < w[i*DW +: DW] || (w[j*DW +: DW] == w[i*DW +: DW] && j < i)) r++;
      s[r*SW +: SW] = SW'(i);
    end
    return s;
  endfunction

  // Sorter model: finish one cycle after the start pulse, ranks the cycle after, then garbage.
  initial begin
    int phase;
    logic [SW*DN-1:0] s;
    phase = 0;
    bus.sort_finish = 1'b0;
    bus.sequence_sorted = '0;
    forever begin
      @(negedge clk);
      bus.sort_finish = 1'b0;
      case (phase)
        1: begin bus.sort_finish = 1'b1; phase = 2; end
        2: begin s = compute_seq(cur_win); bus.sequence_sorted = s; phase = 3; end
        3: begin bus.sequence_sorted = '0; phase = 0; end
        default: if (bus.sort_sig && sorter_on) phase = 1;
      endcase
      if (spur_req != spur_ack) begin
        bus.sort_finish = 1'b1;
        spur_ack = spur_req;
      end
    end
  end

  task automatic send_window(input logic [DW*DN-1:0] w, output bit accepted);
    cur_win = w;
    bus.win_data = w;
    bus.win_valid = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) begin
      if (bus.win_ready) accepted = 1'b1;
      @(negedge clk);
    end
    bus.win_valid = 1'b0;
  endtask

  task automatic wait_mean(input int limit, output bit seen, output int cycles);
    seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < limit) begin
      if (bus.mean_valid) seen = 1'b1;
      else begin
        @(negedge clk);
        cycles++;
      end
    end
  endtask

  task automatic run_window(input logic [DW*DN-1:0] w, output bit seen,
                            output logic [DW-1:0] md, output logic err);
    bit acc;
    int cyc;
    send_window(w, acc);
    wait_mean(300, seen, cyc);
    md = bus.mean_data;
    err = bus.err_timeout;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.win_valid = 1'b0;
    bus.win_data = '0;
    bus.mean_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (bus.win_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_win_ready got=%0b want=0", bus.win_ready); end
    total++; if (bus.sort_sig !== 1'b0) begin bad++; $display("[TB] FAIL reset_sort_sig got=%0b want=0", bus.sort_sig); end
    total++; if (bus.mean_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_mean_valid got=%0b want=0", bus.mean_valid); end
    total++; if (bus.err_timeout !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%0b want=0", bus.err_timeout); end
    total++; if (bus.mean_data !== 8'd0) begin bad++; $display("[TB] FAIL reset_mean_data got=%0d want=0", bus.mean_data); end
    total++; if (bus.sort_data !== '0) begin bad++; $display("[TB] FAIL reset_sort_data got=%0h want=0", bus.sort_data); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.win_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_release_ready got=%0b want=1", bus.win_ready); end
  endtask

  task automatic test_mean(input string name, input logic [DW*DN-1:0] w, input logic [DW-1:0] want);
    bit seen;
    logic [DW-1:0] md;
    logic err;
    run_window(w, seen, md, err);
    total++; if (!seen) begin bad++; $display("[TB] FAIL %s_timeout no mean_valid within bound", name); end
    total++; if (md !== want) begin bad++; $display("[TB] FAIL %s_mean got=%0d want=%0d", name, md, want); end
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL %s_err got=%0b want=0", name, err); end
  endtask

  task automatic test_patterns;
    logic [DW*DN-1:0] w;
    for (int i = 0; i < DN; i++) w[i*DW +: DW] = 8'd10;
    test_mean("flat", w, 8'd10);
    for (int i = 0; i < DN; i++) w[i*DW +: DW] = DW'(i);
    test_mean("ramp", w, 8'd12);
    for (int i = 0; i < DN; i++) begin
      w[i*DW +: DW] = 8'd100;
      if (i == 1 || i == 7 || i == 13 || i == 19) w[i*DW +: DW] = 8'd255;
      if (i == 3 || i == 9 || i == 15 || i == 21) w[i*DW +: DW] = 8'd0;
    end
    test_mean("outliers", w, 8'd100);
  endtask

  task automatic test_back_to_back;
    logic [DW*DN-1:0] w, w2;
    bit acc, seen;
    int cyc;
    for (int i = 0; i < DN; i++) w[i*DW +: DW] = DW'(2 * i);
    for (int i = 0; i < DN; i++) w2[i*DW +: DW] = 8'd7;
    bus.mean_ready = 1'b0;
    send_window(w, acc);
    wait_mean(300, seen, cyc);
    total++; if (!seen) begin bad++; $display("[TB] FAIL b2b_first_timeout no mean_valid"); end
    cur_win = w2;
    bus.win_data = w2;
    bus.win_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++; if (bus.mean_valid !== 1'b1) begin bad++; $display("[TB] FAIL hold_valid cyc=%0d got=%0b want=1", i, bus.mean_valid); end
      total++; if (bus.mean_data !== 8'd24) begin bad++; $display("[TB] FAIL hold_data cyc=%0d got=%0d want=24", i, bus.mean_data); end
      total++; if (bus.win_ready !== 1'b0) begin bad++; $display("[TB] FAIL hold_ready cyc=%0d got=%0b want=0", i, bus.win_ready); end
      @(negedge clk);
    end
    bus.mean_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.mean_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_valid_drop got=%0b want=0", bus.mean_valid); end
    total++; if (bus.win_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready got=%0b want=1", bus.win_ready); end
    @(negedge clk);
    bus.win_valid = 1'b0;
    total++; if (bus.sort_sig !== 1'b1) begin bad++; $display("[TB] FAIL b2b_launch got=%0b want=1", bus.sort_sig); end
    wait_mean(300, seen, cyc);
    total++; if (!seen || bus.mean_data !== 8'd7) begin bad++; $display("[TB] FAIL b2b_second seen=%0b got=%0d want=7", seen, bus.mean_data); end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    logic [DW*DN-1:0] w;
    bit acc, seen;
    int cyc, hits;
    for (int i = 0; i < DN; i++) w[i*DW +: DW] = DW'(i);
    w[12*DW +: DW] = 8'd77;
    sorter_on = 1'b0;
    send_window(w, acc);
`ifdef ALPHA_TRIM_TIMEOUT_EN
    wait_mean(100, seen, cyc);
    total++; if (!seen) begin bad++; $display("[TB] FAIL to_seen no mean_valid"); end
    total++; if (cyc != 16) begin bad++; $display("[TB] FAIL to_latency got=%0d want=16", cyc); end
    total++; if (bus.err_timeout !== 1'b1) begin bad++; $display("[TB] FAIL to_err got=%0b want=1", bus.err_timeout); end
    total++; if (bus.mean_data !== 8'd77) begin bad++; $display("[TB] FAIL to_data got=%0d want=77", bus.mean_data); end
    @(negedge clk);
    total++; if (bus.err_timeout !== 1'b0) begin bad++; $display("[TB] FAIL to_err_clear got=%0b want=0", bus.err_timeout); end
    sorter_on = 1'b1;
`else
    hits = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.mean_valid) hits++;
      @(negedge clk);
    end
    total++; if (hits != 0) begin bad++; $display("[TB] FAIL wait_forever valid_cycles=%0d want=0", hits); end
    total++; if (bus.win_ready !== 1'b0) begin bad++; $display("[TB] FAIL wait_ready got=%0b want=0", bus.win_ready); end
    total++; if (bus.err_timeout !== 1'b0) begin bad++; $display("[TB] FAIL wait_err got=%0b want=0", bus.err_timeout); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sorter_on = 1'b1;
    @(negedge clk);
    total++; if (bus.win_ready !== 1'b1) begin bad++; $display("[TB] FAIL wait_recover got=%0b want=1", bus.win_ready); end
`endif
  endtask

  task automatic test_reset_mid;
    logic [DW*DN-1:0] w;
    bit acc;
    int hits;
    for (int i = 0; i < DN; i++) w[i*DW +: DW] = DW'(i);
    send_window(w, acc);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus.win_ready !== 1'b0) begin bad++; $display("[TB] FAIL mid_ready got=%0b want=0", bus.win_ready); end
    total++; if (bus.mean_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_valid got=%0b want=0", bus.mean_valid); end
    total++; if (bus.sort_data !== '0) begin bad++; $display("[TB] FAIL mid_sort_data got=%0h want=0", bus.sort_data); end
    total++; if (bus.mean_data !== 8'd0) begin bad++; $display("[TB] FAIL mid_mean_data got=%0d want=0", bus.mean_data); end
    total++; if (bus.sort_sig !== 1'b0) begin bad++; $display("[TB] FAIL mid_sort_sig got=%0b want=0", bus.sort_sig); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.win_ready !== 1'b1) begin bad++; $display("[TB] FAIL mid_release got=%0b want=1", bus.win_ready); end
    spur_req++;
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.mean_valid || bus.sort_sig || !bus.win_ready) hits++;
      @(negedge clk);
    end
    total++; if (hits != 0) begin bad++; $display("[TB] FAIL spurious_finish disturbed_cycles=%0d want=0", hits); end
    for (int i = 0; i < DN; i++) w[i*DW +: DW] = 8'd200;
    test_mean("after_reset", w, 8'd200);
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
